// File: rtl/clock_div_prog_pkg.sv
// Shared timebase constants for the watch divider chain.
// Each stage of the chain is a clock_div_prog instance using one of these ratios.
package clock_div_prog_pkg;

    localparam int TB_DIV_HUNDREDTHS = 100;
    localparam int TB_DIV_MILLI      = 1000;
    localparam int TB_DIV_DECADE     = 10;

endpackage

// File: rtl/clock_div_prog.sv
// Programmable clock-enable divider: one registered div_tick per N source ticks,
// a near-50% square wave, and a divisor that changes only on safe boundaries.
module clock_div_prog
    import clock_div_prog_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = TB_DIV_MILLI
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic             clk_source,
    input  logic             run,
    input  logic             clear,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_value,
    output logic             div_tick,
    output logic             div_square,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] div_cur,
    output logic             load_pending
);

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_cur_q, div_cur_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_flag_q, pend_flag_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;

    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] div_apply;
    logic [WIDTH-1:0] cnt_inc;
    logic             at_term;

    always_comb begin
        load_val  = (div_value == '0) ? ONE : div_value;
        at_term   = (cnt_q == (div_cur_q - ONE));
        cnt_inc   = cnt_q + ONE;
        // Divisor that takes effect if this edge is an application point;
        // a same-cycle load beats an older pending value.
        div_apply = div_load ? load_val : (pend_flag_q ? pend_q : div_cur_q);

        cnt_d       = cnt_q;
        div_cur_d   = div_cur_q;
        pend_d      = div_load ? load_val : pend_q;
        pend_flag_d = pend_flag_q | div_load;
        tick_d      = 1'b0;
        sq_d        = sq_q;

        if (clear) begin
            div_cur_d   = div_apply;
            pend_flag_d = 1'b0;
            cnt_d       = '0;
            sq_d        = (div_apply > ONE);
        end else if (!run) begin
            // Count is frozen, so a new divisor can be applied at once.
            div_cur_d   = div_apply;
            pend_flag_d = 1'b0;
            if (div_load || pend_flag_q) begin
                if (cnt_q >= div_apply) begin
                    cnt_d = '0;
                    sq_d  = (div_apply > ONE);
                end else begin
                    sq_d  = (cnt_q < (div_apply >> 1));
                end
            end
        end else if (clk_source) begin
            if (at_term) begin
                cnt_d       = '0;
                tick_d      = 1'b1;
                div_cur_d   = div_apply;
                pend_flag_d = 1'b0;
                sq_d        = (div_apply > ONE);
            end else begin
                cnt_d = cnt_inc;
                sq_d  = (cnt_inc < (div_cur_q >> 1));
            end
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            cnt_q       <= '0;
            div_cur_q   <= DIV_RST;
            pend_q      <= DIV_RST;
            pend_flag_q <= 1'b0;
            tick_q      <= 1'b0;
            sq_q        <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            div_cur_q   <= div_cur_d;
            pend_q      <= pend_d;
            pend_flag_q <= pend_flag_d;
            tick_q      <= tick_d;
            sq_q        <= sq_d;
        end
    end

    assign div_tick     = tick_q;
    assign div_square   = sq_q;
    assign cnt          = cnt_q;
    assign div_cur      = div_cur_q;
    assign load_pending = pend_flag_q;

endmodule

// File: tb/tb_clock_div_prog.sv
// Self-checking bench for clock_div_prog: fixed vector table, directed
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_clock_div_prog;

    logic        clk;
    logic        reset_p;
    logic        clk_source;
    logic        run;
    logic        clear;
    logic        div_load;
    logic [15:0] div_value;
    logic        div_tick;
    logic        div_square;
    logic [15:0] cnt;
    logic [15:0] div_cur;
    logic        load_pending;

    int n_checks;
    int n_errors;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    clock_div_prog #(
        .WIDTH       (16),
        .DEFAULT_DIV (1000)
    ) dut (
        .clk          (clk),
        .reset_p      (reset_p),
        .clk_source   (clk_source),
        .run          (run),
        .clear        (clear),
        .div_load     (div_load),
        .div_value    (div_value),
        .div_tick     (div_tick),
        .div_square   (div_square),
        .cnt          (cnt),
        .div_cur      (div_cur),
        .load_pending (load_pending)
    );

    // ---------------- reference model ----------------
    // Count of source ticks in the current period, divisor, pending divisor.
    // The square output is "cnt in the first half of the period" once any
    // count/clear/apply event has happened; it is 0 straight out of reset.
    int m_cnt;
    int m_div;
    int m_pend;
    bit m_has_pend;
    bit m_tick;
    bit m_live;

    function automatic int m_sq();
        return (m_live && (m_cnt < m_div / 2)) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_cnt      = 0;
        m_div      = 1000;
        m_pend     = 1000;
        m_has_pend = 1'b0;
        m_tick     = 1'b0;
        m_live     = 1'b0;
    endtask

    task automatic model_step(input int r, input int s, input int c, input int l, input int v);
        int lv;
        int next_div;
        lv       = (v == 0) ? 1 : v;
        next_div = (l != 0) ? lv : (m_has_pend ? m_pend : m_div);
        m_tick   = 1'b0;
        if (c != 0) begin
            m_div      = next_div;
            m_has_pend = 1'b0;
            m_cnt      = 0;
            m_live     = 1'b1;
        end else if (r == 0) begin
            if (l != 0 || m_has_pend) begin
                m_div      = next_div;
                m_has_pend = 1'b0;
                m_live     = 1'b1;
                if (m_cnt >= m_div) m_cnt = 0;
            end
        end else if (s != 0) begin
            m_live = 1'b1;
            if (m_cnt + 1 == m_div) begin
                m_cnt      = 0;
                m_tick     = 1'b1;
                m_div      = next_div;
                m_has_pend = 1'b0;
            end else begin
                m_cnt = m_cnt + 1;
                if (l != 0) begin
                    m_pend     = lv;
                    m_has_pend = 1'b1;
                end
            end
        end else if (l != 0) begin
            m_pend     = lv;
            m_has_pend = 1'b1;
        end
    endtask

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".cnt"},          int'(cnt),          m_cnt);
        check({tag, ".div_tick"},     int'(div_tick),     int'(m_tick));
        check({tag, ".div_square"},   int'(div_square),   m_sq());
        check({tag, ".div_cur"},      int'(div_cur),      m_div);
        check({tag, ".load_pending"}, int'(load_pending), int'(m_has_pend));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input int r, input int s, input int c, input int l, input int v);
        run        = (r != 0);
        clk_source = (s != 0);
        clear      = (c != 0);
        div_load   = (l != 0);
        div_value  = 16'(v);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input int r, input int s, input int c, input int l, input int v);
        model_step(r, s, c, l, v);
        drive(r, s, c, l, v);
        check_model(tag);
    endtask

    task automatic do_reset();
        reset_p    = 1'b1;
        clk_source = 1'b0;
        run        = 1'b0;
        clear      = 1'b0;
        div_load   = 1'b0;
        div_value  = '0;
        @(posedge clk);
        #1;
        model_reset();
        check_model("reset");
        @(negedge clk);
        reset_p = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int run, src, clr, ld, val;
        int e_cnt, e_tick, e_sq, e_div, e_pend;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int ticks;
        int first_tick;
        int tick_at[$];
        int sq_high;

        n_checks = 0;
        n_errors = 0;

        vecs[0]  = '{0, 0, 0, 1, 0,  0, 0, 0, 1, 0};
        vecs[1]  = '{1, 1, 0, 0, 0,  0, 1, 0, 1, 0};
        vecs[2]  = '{1, 0, 0, 0, 0,  0, 0, 0, 1, 0};
        vecs[3]  = '{1, 1, 0, 1, 4,  0, 1, 1, 4, 0};
        vecs[4]  = '{1, 1, 0, 0, 0,  1, 0, 1, 4, 0};
        vecs[5]  = '{1, 1, 0, 1, 3,  2, 0, 0, 4, 1};
        vecs[6]  = '{1, 1, 0, 0, 0,  3, 0, 0, 4, 1};
        vecs[7]  = '{1, 1, 0, 0, 0,  0, 1, 1, 3, 0};
        vecs[8]  = '{1, 1, 1, 0, 0,  0, 0, 1, 3, 0};
        vecs[9]  = '{1, 1, 0, 0, 0,  1, 0, 0, 3, 0};
        vecs[10] = '{0, 0, 0, 1, 1,  0, 0, 0, 1, 0};
        vecs[11] = '{1, 1, 0, 1, 2,  0, 1, 1, 2, 0};
        vecs[12] = '{1, 1, 0, 0, 0,  1, 0, 0, 2, 0};
        vecs[13] = '{1, 0, 0, 1, 7,  1, 0, 0, 2, 1};
        vecs[14] = '{0, 0, 0, 0, 0,  1, 0, 1, 7, 0};

        // Table-driven vectors straight after reset.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].run, vecs[i].src, vecs[i].clr, vecs[i].ld, vecs[i].val);
            check($sformatf("vec%0d.cnt", i),          int'(cnt),          vecs[i].e_cnt);
            check($sformatf("vec%0d.div_tick", i),     int'(div_tick),     vecs[i].e_tick);
            check($sformatf("vec%0d.div_square", i),   int'(div_square),   vecs[i].e_sq);
            check($sformatf("vec%0d.div_cur", i),      int'(div_cur),      vecs[i].e_div);
            check($sformatf("vec%0d.load_pending", i), int'(load_pending), vecs[i].e_pend);
        end

        // Default divisor 1000, source every 4th clk: ticks at 3999 and 7999.
        do_reset();
        ticks      = 0;
        first_tick = -1;
        for (int i = 0; i < 8004; i++) begin
            cyc("div1000", 1, (i % 4 == 3) ? 1 : 0, 0, 0, 0);
            if (div_tick) begin
                if (first_tick < 0) first_tick = i;
                ticks++;
            end
        end
        check("div1000.first_tick_cycle", first_tick, 3999);
        check("div1000.tick_count", ticks, 2);

        // Mid-period load of 10 at cnt=300: old period completes first.
        do_reset();
        for (int i = 0; i < 300; i++) cyc("midload.pre", 1, 1, 0, 0, 0);
        cyc("midload.load", 1, 0, 0, 1, 10);
        check("midload.pending_set", int'(load_pending), 1);
        check("midload.div_unchanged", int'(div_cur), 1000);
        tick_at.delete();
        for (int i = 0; i < 730; i++) begin
            cyc("midload.run", 1, 1, 0, 0, 0);
            if (div_tick) tick_at.push_back(i);
        end
        check("midload.tick_count", tick_at.size(), 4);
        if (tick_at.size() == 4) begin
            check("midload.first_wrap", tick_at[0], 699);
            check("midload.second_period", tick_at[1] - tick_at[0], 10);
            check("midload.third_period", tick_at[2] - tick_at[1], 10);
        end
        check("midload.div_after", int'(div_cur), 10);

        // Divisor 5 with clk_source held high: tick every 5, square 2 high / 3 low.
        do_reset();
        cyc("div5.load", 0, 0, 0, 1, 5);
        ticks   = 0;
        sq_high = 0;
        for (int i = 0; i < 20; i++) begin
            cyc("div5.run", 1, 1, 0, 0, 0);
            if (div_tick) ticks++;
            if (div_square) sq_high++;
        end
        check("div5.tick_count", ticks, 4);
        check("div5.square_high", sq_high, 8);

        // Clear together with a source tick at cnt=7 of 10.
        do_reset();
        cyc("clear.load", 0, 0, 0, 1, 10);
        for (int i = 0; i < 7; i++) cyc("clear.pre", 1, 1, 0, 0, 0);
        check("clear.cnt_before", int'(cnt), 7);
        cyc("clear.hit", 1, 1, 1, 0, 0);
        check("clear.cnt", int'(cnt), 0);
        check("clear.no_tick", int'(div_tick), 0);
        check("clear.square", int'(div_square), 1);
        tick_at.delete();
        for (int i = 0; i < 12; i++) begin
            cyc("clear.post", 1, 1, 0, 0, 0);
            if (div_tick) tick_at.push_back(i);
        end
        check("clear.post_ticks", tick_at.size(), 1);
        if (tick_at.size() == 1) check("clear.tick_index", tick_at[0], 9);

        // Pause at cnt=3 for 50 source ticks, then resume.
        do_reset();
        cyc("pause.load", 0, 0, 0, 1, 10);
        for (int i = 0; i < 3; i++) cyc("pause.pre", 1, 1, 0, 0, 0);
        ticks = 0;
        for (int i = 0; i < 50; i++) begin
            cyc("pause.hold", 0, 1, 0, 0, 0);
            if (div_tick) ticks++;
        end
        check("pause.cnt_held", int'(cnt), 3);
        cyc("pause.resume", 1, 1, 0, 0, 0);
        check("pause.resume_cnt", int'(cnt), 4);
        for (int i = 0; i < 6; i++) begin
            cyc("pause.post", 1, 1, 0, 0, 0);
            if (div_tick) ticks++;
        end
        check("pause.tick_count", ticks, 1);

        // Reset while a load is pending drops it.
        cyc("rstpend.load", 1, 0, 0, 1, 33);
        check("rstpend.pending", int'(load_pending), 1);
        do_reset();

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            int r, s, c, l, v;
            r = ($urandom_range(0, 9) != 0) ? 1 : 0;
            s = $urandom_range(0, 1);
            c = ($urandom_range(0, 31) == 0) ? 1 : 0;
            l = ($urandom_range(0, 15) == 0) ? 1 : 0;
            v = $urandom_range(0, 12);
            cyc("rand", r, s, c, l, v);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
